// File: rtl/gray_conv_sched.sv
// gray_conv_sched: round-robin scheduler in front of one shared binary/Gray
// conversion datapath. One pending request is granted per cycle. Its operand
// is converted and then held in a registered valid/ready output slot, tagged
// with the ID of the requester that owns it.
//
// Build option: define GRAY_SCHED_G2B_EN to honour dir_i for each requester.
// With GRAY_SCHED_G2B_EN defined, both conversion directions are built.
// Without it, every request is converted binary->Gray and no Gray->binary
// logic exists.
//
// Output slot control states:
//   state | meaning
//   EMPTY | no result held, dout_valid_o low
//   FULL  | result held in dout_o/dout_id_o, waiting for dout_ready_i
module gray_conv_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] din_i,
  input  logic [NREQ-1:0]       dir_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]      dout_o,
  output logic [IDW-1:0]        dout_id_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  busy_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             can_accept;
  logic             found;
  logic             grant_valid;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] op;
  logic             op_dir;
  logic [WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef GRAY_SCHED_G2B_EN
  // Prefix XOR running down from the MSB.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction
`endif

  // The slot can take a new result if it is empty or is drained in this same cycle.
  assign dout_valid_o = (state_q == FULL);
  assign can_accept   = !dout_valid_o || dout_ready_i;

  // Rotating-priority search for the first requester, starting at ptr_q.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign grant_valid = found && can_accept && !rst_i;
  assign gnt_o       = grant_valid ? (NREQ'(1) << win_idx) : '0;

  // Select the operand and direction of the winning requester.
  always_comb begin
    op     = '0;
    op_dir = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win_idx) begin
        op     = din_i[k*WIDTH +: WIDTH];
        op_dir = dir_i[k];
      end
    end
  end

`ifdef GRAY_SCHED_G2B_EN
  assign result = op_dir ? gray2bin(op) : bin2gray(op);
`else
  // The direction input has no effect when only binary->Gray is built.
  logic unused_dir;
  assign unused_dir = op_dir ^ (^dir_i);
  assign result     = bin2gray(op);
`endif

  // Next-state logic for the output slot, the result registers and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    id_d    = id_q;
    ptr_d   = ptr_q;

    case (state_q)
      EMPTY: begin
        if (grant_valid) state_d = FULL;
      end
      FULL: begin
        if (grant_valid)       state_d = FULL;
        else if (dout_ready_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (grant_valid) begin
      dout_d = result;
      id_d   = win_idx;
      ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end
  end

  // State and data registers. Reset discards any pending result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      dout_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign dout_o    = dout_q;
  assign dout_id_o = id_q;
  assign busy_o    = !rst_i && (dout_valid_o || (|req_i));

  // At most one grant can be active in any cycle.
  a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));

  // A stalled result holds steady until it is consumed.
  a_stall_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (dout_valid_o && !dout_ready_i) |=>
      (dout_valid_o && $stable(dout_o) && $stable(dout_id_o)));

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed bench for gray_conv_sched (NREQ=4, WIDTH=4).
// The expected values for dir=1 depend on whether GRAY_SCHED_G2B_EN is defined.
module tb_gray_conv_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [15:0] din_i;
  logic [3:0]  dir_i;
  logic [3:0]  gnt_o;
  logic [3:0]  dout_o;
  logic [1:0]  dout_id_o;
  logic        dout_valid_o;
  logic        dout_ready_i;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_b2g [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                               4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [3:0] exp_rr [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};

  gray_conv_sched #(.NREQ(4), .WIDTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .din_i        (din_i),
    .dir_i        (dir_i),
    .gnt_o        (gnt_o),
    .dout_o       (dout_o),
    .dout_id_o    (dout_id_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = '0; din_i = '0; dir_i = '0; dout_ready_i = 1'b1;
    tick(); tick();
    tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt_o); end
    tests++; if (dout_o !== 4'b0000) begin fails++; $display("FAIL reset_dout got %b want 0000", dout_o); end
    tests++; if (dout_id_o !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", dout_id_o); end
    tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", dout_valid_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_b2g();
    req_i = 4'b0010; din_i = '0; din_i[7:4] = 4'b0101; dir_i = '0; dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0010) begin fails++; $display("FAIL single_gnt got %b want 0010", gnt_o); end
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy_o); end
    tick();
    req_i = '0;
    tests++; if (dout_o !== 4'b0111) begin fails++; $display("FAIL single_dout got %b want 0111", dout_o); end
    tests++; if (dout_id_o !== 2'd1) begin fails++; $display("FAIL single_id got %0d want 1", dout_id_o); end
    tests++; if (dout_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", dout_valid_o); end
    tick();
    tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", dout_valid_o); end
    tests++; if (dout_o !== 4'b0111) begin fails++; $display("FAIL single_dout_hold got %b want 0111", dout_o); end
  endtask

  task automatic test_g2b();
    logic [3:0] want;
`ifdef GRAY_SCHED_G2B_EN
    want = 4'b0101;
`else
    want = 4'b0100;
`endif
    req_i = 4'b0100; din_i = '0; din_i[11:8] = 4'b0111; dir_i = 4'b0100; dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0100) begin fails++; $display("FAIL g2b_gnt got %b want 0100", gnt_o); end
    tick();
    req_i = '0; dir_i = '0;
    tests++; if (dout_o !== want) begin fails++; $display("FAIL g2b_dout got %b want %b", dout_o, want); end
    tests++; if (dout_id_o !== 2'd2) begin fails++; $display("FAIL g2b_id got %0d want 2", dout_id_o); end
    tick();
  endtask

  task automatic test_round_robin();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_i = 4'b1111; din_i = {4'b1000, 4'b0100, 4'b0010, 4'b0001}; dir_i = '0; dout_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (gnt_o !== (4'b0001 << (k % 4))) begin
        fails++; $display("FAIL rr_gnt step %0d got %b want %b", k, gnt_o, 4'b0001 << (k % 4));
      end
      tick();
      tests++;
      if (dout_id_o !== 2'(k % 4) || dout_valid_o !== 1'b1 || dout_o !== exp_rr[k % 4]) begin
        fails++; $display("FAIL rr_out step %0d got id=%0d v=%b d=%b want id=%0d v=1 d=%b",
                          k, dout_id_o, dout_valid_o, dout_o, k % 4, exp_rr[k % 4]);
      end
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_backpressure();
    req_i = 4'b0001; din_i = '0; din_i[3:0] = 4'b1011; dir_i = '0; dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0001) begin fails++; $display("FAIL bp_first_gnt got %b want 0001", gnt_o); end
    tick();
    din_i[3:0] = 4'b0011; dout_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (gnt_o !== 4'b0000 || dout_o !== 4'b1110 || dout_valid_o !== 1'b1) begin
        fails++; $display("FAIL bp_stall cycle %0d got gnt=%b d=%b v=%b want gnt=0000 d=1110 v=1",
                          k, gnt_o, dout_o, dout_valid_o);
      end
      tick();
    end
    dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0001) begin fails++; $display("FAIL bp_release_gnt got %b want 0001", gnt_o); end
    tick();
    req_i = '0;
    tests++;
    if (dout_o !== 4'b0010 || dout_valid_o !== 1'b1 || dout_id_o !== 2'd0) begin
      fails++; $display("FAIL bp_next got d=%b v=%b id=%0d want d=0010 v=1 id=0", dout_o, dout_valid_o, dout_id_o);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    req_i = 4'b1000; din_i = '0; dir_i = '0; dout_ready_i = 1'b1;
    for (int v = 0; v < 16; v++) begin
      din_i[15:12] = 4'(v);
      #1;
      tests++; if (gnt_o !== 4'b1000) begin fails++; $display("FAIL exh_gnt v=%0d got %b want 1000", v, gnt_o); end
      tick();
      tests++;
      if (dout_o !== exp_b2g[v] || dout_id_o !== 2'd3) begin
        fails++; $display("FAIL exh_dout v=%0d got d=%b id=%0d want d=%b id=3", v, dout_o, dout_id_o, exp_b2g[v]);
      end
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    req_i = 4'b0010; din_i = '0; din_i[7:4] = 4'b0001; dir_i = '0; dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0010) begin fails++; $display("FAIL rst_setup_gnt got %b want 0010", gnt_o); end
    tick();
    req_i = '0; dout_ready_i = 1'b0;
    tick();
    tests++; if (dout_valid_o !== 1'b1 || dout_o !== 4'b0001) begin
      fails++; $display("FAIL rst_setup_stall got v=%b d=%b want v=1 d=0001", dout_valid_o, dout_o);
    end
    rst_i = 1'b1; req_i = 4'b1111; dout_ready_i = 1'b1;
    #1;
    tests++; if (gnt_o !== 4'b0000) begin fails++; $display("FAIL rst_gnt_forced got %b want 0000", gnt_o); end
    req_i = '0;
    tick();
    rst_i = 1'b0;
    #1;
    tests++;
    if (dout_valid_o !== 1'b0 || dout_o !== 4'b0000 || busy_o !== 1'b0) begin
      fails++; $display("FAIL rst_after got v=%b d=%b busy=%b want v=0 d=0000 busy=0", dout_valid_o, dout_o, busy_o);
    end
    req_i = 4'b0110; din_i[7:4] = 4'b0100;
    #1;
    tests++; if (gnt_o !== 4'b0010) begin fails++; $display("FAIL rst_first_gnt got %b want 0010", gnt_o); end
    tick();
    req_i = '0;
    tests++; if (dout_id_o !== 2'd1 || dout_o !== 4'b0110) begin
      fails++; $display("FAIL rst_first_out got id=%0d d=%b want id=1 d=0110", dout_id_o, dout_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_b2g();
    test_g2b();
    test_round_robin();
    test_backpressure();
    test_exhaustive();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
